interrupt_dma_arbiter: RTL

// - Generates int_pending and dma_req, the two trap-request inputs of the microcode sequencer.
// - Resolves device IRQ lines into one prioritised vector and owns the IRQ mask register.
// - Runs the DMA bus request/grant handshake, aligned to microcode fetch boundaries.
// - Sits between the peripheral IRQ/DMA pins and the sequencer; driven by the ctrl_int_ack,

---
 rtl/interrupt_dma_arbiter_pkg.sv | 33 +++
 rtl/interrupt_dma_arbiter_sync.sv | 23 ++
 rtl/interrupt_dma_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/interrupt_dma_arbiter_pkg.sv
// Shared types and helpers for the interrupt/DMA arbiter.
// Optional build macro used by the arbiter: IRQ_EDGE_TRIGGER_EN (edge-triggered IRQ pending).
package interrupt_dma_arbiter_pkg;

  localparam int unsigned IRQ_MAX   = 8;
  localparam int unsigned IRQ_IDX_W = $clog2(IRQ_MAX);

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_REQ,
    DMA_GRANT,
    DMA_RELEASE
  } e_dma_state;

  typedef struct packed {
    logic                 found;
    logic [IRQ_IDX_W-1:0] idx;
  } irq_sel_t;

  // Lowest set bit wins; found=0 when nothing is requesting.
  function automatic irq_sel_t lowest_irq(input logic [IRQ_MAX-1:0] req);
    irq_sel_t sel;
    sel = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel.found = 1'b1;
        sel.idx   = IRQ_IDX_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/interrupt_dma_arbiter_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous device lines.
module irq_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/interrupt_dma_arbiter.sv
// IRQ prioritisation, mask register and DMA request/grant handshake feeding the sequencer.
// Build macro: IRQ_EDGE_TRIGGER_EN selects edge-triggered pending; default is level mode.
module interrupt_dma_arbiter
  import interrupt_dma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter logic [7:0]  VECTOR_BASE = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               dma_req_in,
  input  logic [7:0]         z_bus,
  input  logic               irq_en,
  input  logic               u_fetch_boundary,
  input  logic               ctrl_int_ack,
  input  logic               ctrl_clear_all_ints,
  input  logic               ctrl_irq_masks_wrt,
  output logic               int_pending,
  output logic               dma_req,
  output logic               dma_grant,
  output logic [7:0]         int_vector,
  output logic [NUM_IRQ-1:0] irq_mask
);

  logic [NUM_IRQ-1:0] irq_sync;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic               dma_sync;
  logic [IRQ_MAX-1:0] active;
  irq_sel_t           sel;
  logic [7:0]         vector_nxt;
  logic               ack_hit;
  e_dma_state         dma_state;
  e_dma_state         dma_state_nxt;
  logic               dma_req_nxt;
  logic               dma_grant_nxt;

  irq_sync2 #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_in),
    .q     (irq_sync)
  );

  irq_sync2 #(.WIDTH(1)) u_dma_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dma_req_in),
    .q     (dma_sync)
  );

  // Ack always arbitrates against the mask as it stood before any same-cycle write.
  assign active      = IRQ_MAX'(pending & irq_mask);
  assign sel         = lowest_irq(active);
  assign ack_hit     = ctrl_int_ack & sel.found;
  assign vector_nxt  = VECTOR_BASE + 8'({sel.idx, 1'b0});
  assign int_pending = irq_en & (|(pending & irq_mask)) & (dma_state == DMA_IDLE);

`ifdef IRQ_EDGE_TRIGGER_EN
  logic [NUM_IRQ-1:0] irq_prev;
  logic [IRQ_MAX-1:0] ack_onehot;

  always_ff @(posedge clk) begin
    if (!rst_n) irq_prev <= '0;
    else        irq_prev <= irq_sync;
  end

  // New rising edges are ORed in after the ack clear so they survive it; clear-all wins.
  always_comb begin
    ack_onehot  = '0;
    if (ack_hit) ack_onehot = IRQ_MAX'(1) << sel.idx;
    pending_nxt = (pending & ~NUM_IRQ'(ack_onehot)) | (irq_sync & ~irq_prev);
    if (ctrl_clear_all_ints) pending_nxt = '0;
  end
`else
  logic clear_all_unused;

  assign clear_all_unused = ctrl_clear_all_ints;

  always_comb begin
    pending_nxt = irq_sync;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      irq_mask   <= '0;
      int_vector <= VECTOR_BASE;
    end else begin
      pending <= pending_nxt;
      if (ctrl_irq_masks_wrt) irq_mask   <= z_bus[NUM_IRQ-1:0];
      if (ack_hit)            int_vector <= vector_nxt;
    end
  end

  // DMA handshake state register; request/grant are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dma_state <= DMA_IDLE;
      dma_req   <= 1'b0;
      dma_grant <= 1'b0;
    end else begin
      dma_state <= dma_state_nxt;
      dma_req   <= dma_req_nxt;
      dma_grant <= dma_grant_nxt;
    end
  end

  always_comb begin
    dma_state_nxt = dma_state;
    case (dma_state)
      DMA_IDLE:    if (dma_sync)         dma_state_nxt = DMA_REQ;
      DMA_REQ:     if (u_fetch_boundary) dma_state_nxt = DMA_GRANT;
      DMA_GRANT:   if (!dma_sync)        dma_state_nxt = DMA_RELEASE;
      DMA_RELEASE:                       dma_state_nxt = DMA_IDLE;
      default:                           dma_state_nxt = DMA_IDLE;
    endcase
    dma_req_nxt   = (dma_state_nxt == DMA_REQ) || (dma_state_nxt == DMA_GRANT);
    dma_grant_nxt = (dma_state_nxt == DMA_GRANT);
  end

endmodule
